// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the queued instruction-fetch stage:
//   - default widths and queue depth
//   - the NOP encoding presented to decode when no instruction is valid
//   - the next-PC source selector used by the fetch PC register
//   - helper functions that compute branch and jump targets
// The target functions work on 64-bit values so that any ADDR_W up to 64
// can share them; callers zero-extend their operands and truncate the
// result back to ADDR_W, which also gives the modulo-2^ADDR_W wrap.
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned JADDR_W_DEF = 26;
  localparam int unsigned DEPTH_DEF   = 4;

  // All-zero word doubles as the NOP handed to decode when nothing is valid
  localparam logic [DATA_W_DEF-1:0] NOP = '0;

  // Where the fetch PC comes from on the next edge
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_e;

  // Branch target: the word after the branch plus a two's-complement offset.
  // Zero-extended operands are fine because only the low ADDR_W bits of the
  // sum are kept by the caller.
  function automatic logic [63:0] branchTarget(input logic [63:0] redirectPc,
                                               input logic [63:0] offset);
    return redirectPc + 64'd1 + offset;
  endfunction

  // Jump target: the top four bits of the word after the jump are kept, the
  // low jaddrW bits come from the jump field, and anything in between is zero.
  function automatic logic [63:0] jumpTarget(input logic [63:0] redirectPc,
                                             input logic [63:0] jumpAddress,
                                             input int unsigned addrW,
                                             input int unsigned jaddrW);
    logic [63:0] nextPc;
    logic [63:0] topMask;
    logic [63:0] fieldMask;
    nextPc    = redirectPc + 64'd1;
    topMask   = ~((64'd1 << (addrW - 4)) - 64'd1);
    fieldMask = (64'd1 << jaddrW) - 64'd1;
    return (nextPc & topMask) | (jumpAddress & fieldMask);
  endfunction

endpackage

// File: rtl/if_stage_queued_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {pc, instruction} pairs between the
// instruction memory and decode.
//   Clk_i       clock, all updates on the rising edge
//   Reset_i     asynchronous active-high reset, empties the queue
//   Clear_i     synchronous flush, wins over push and pop
//   Push_i      write PushData_i at the tail
//   PushData_i  entry to write
//   Pop_i       drop the head entry (ignored when empty)
//   HeadData_o  current head entry, valid whenever Count_o != 0
//   Count_o     number of stored entries, 0..DEPTH
// A pop in the same cycle as a push always removes the entry that was at the
// head before the push, so a push into an empty queue is not visible to the
// pop of that same cycle.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           Clk_i,
  input  logic                           Reset_i,
  input  logic                           Clear_i,
  input  logic                           Push_i,
  input  logic [WIDTH-1:0]               PushData_i,
  input  logic                           Pop_i,
  output logic [WIDTH-1:0]               HeadData_o,
  output logic [$clog2(DEPTH+1)-1:0]     Count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushEn;
  logic             popEn;

  // Pointers wrap explicitly so DEPTH does not have to be a power of two
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Qualify push and pop: a clear cancels both, pop needs something stored,
  // and a push into a full queue is only taken if the head leaves this cycle
  always_comb begin
    popEn   = Pop_i & ~Clear_i & (count_q != '0);
    pushEn  = Push_i & ~Clear_i & ((count_q != CNT_W'(DEPTH)) | popEn);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (Clear_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (popEn) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      if (pushEn) begin
        wrPtr_d = nextPtr(wrPtr_q);
      end
      if (pushEn && !popEn) begin
        count_d = count_q + CNT_W'(1);
      end else if (popEn && !pushEn) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy state, emptied immediately by reset
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is read until it has been written
  always_ff @(posedge Clk_i) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= PushData_i;
    end
  end

  assign HeadData_o = mem_q[rdPtr_q];
  assign Count_o    = count_q;

endmodule

// File: rtl/if_stage_queued.sv
// ---------------------------------------------------------------------------
// if_stage_queued
// Instruction-fetch stage with a decoupling fetch queue. Word addresses are
// issued to a synchronous instruction memory with one cycle of latency; each
// returned word is queued with its PC and handed to decode one per cycle.
//   Clk_i           clock
//   Reset_i         asynchronous active-high reset
//   Stall_i         decode cannot accept; instruction outputs hold
//   Branch_i        taken-branch redirect
//   Jump_i          jump redirect, wins over Branch_i
//   RedirectPc_i    word PC of the redirecting instruction
//   BranchOffset_i  two's-complement word offset for branches
//   JumpAddress_i   word jump target field
//   ImemReq_o       fetch request this cycle
//   ImemAddr_o      word address of the request
//   ImemData_i      word for the address requested in the previous cycle
//   Inst_o          instruction to decode, NOP when not valid
//   InstPc_o        PC of Inst_o, zero when not valid
//   InstValid_o     Inst_o is a real fetched instruction
// A request is only made when the queue has room for every word already in
// flight plus the new one, so the queue can never overflow.
// ---------------------------------------------------------------------------
module if_stage_queued
  import if_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       JADDR_W  = JADDR_W_DEF,
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clk_i,
  input  logic               Reset_i,
  input  logic               Stall_i,
  input  logic               Branch_i,
  input  logic               Jump_i,
  input  logic [ADDR_W-1:0]  RedirectPc_i,
  input  logic [ADDR_W-1:0]  BranchOffset_i,
  input  logic [JADDR_W-1:0] JumpAddress_i,
  output logic               ImemReq_o,
  output logic [ADDR_W-1:0]  ImemAddr_o,
  input  logic [DATA_W-1:0]  ImemData_i,
  output logic [DATA_W-1:0]  Inst_o,
  output logic [ADDR_W-1:0]  InstPc_o,
  output logic               InstValid_o
);

  localparam int unsigned          CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned          ENTRY_W = ADDR_W + DATA_W;
  localparam logic [CNT_W:0]       DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0]    NOP_W   = DATA_W'(NOP);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflightPc_q, inflightPc_d;
  logic [DATA_W-1:0]  inst_q, inst_d;
  logic [ADDR_W-1:0]  instPc_q, instPc_d;
  logic               instValid_q, instValid_d;

  logic               redirect;
  logic [CNT_W:0]     used;
  logic               issue;
  logic               pop;
  pc_sel_e            pcSel;
  logic [ADDR_W-1:0]  branchTgt;
  logic [ADDR_W-1:0]  jumpTgt;

  logic [CNT_W-1:0]   fifoCount;
  logic [ENTRY_W-1:0] fifoHead;
  logic [ENTRY_W-1:0] fifoPushData;

  // Redirect targets, truncated back to the PC width so they wrap naturally
  always_comb begin
    branchTgt = ADDR_W'(branchTarget(64'(RedirectPc_i), 64'(BranchOffset_i)));
    jumpTgt   = ADDR_W'(jumpTarget(64'(RedirectPc_i), 64'(JumpAddress_i),
                                   ADDR_W, JADDR_W));
  end

  // Credit check and request: queued entries plus the word still coming back
  // from memory must leave a free slot. Nothing is requested in a redirect
  // cycle (the current PC is stale) or while reset is held.
  always_comb begin
    redirect = Jump_i | Branch_i;
    used     = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight_q};
    issue    = ~Reset_i & ~redirect & (used < DEPTH_C);
    pop      = ~redirect & ~Stall_i & (fifoCount != '0);
  end

  // Pick the next fetch PC; jump beats branch, and any redirect beats the
  // sequential increment
  always_comb begin
    pcSel = PC_HOLD;
    if (Jump_i) begin
      pcSel = PC_JUMP;
    end else if (Branch_i) begin
      pcSel = PC_BRANCH;
    end else if (issue) begin
      pcSel = PC_SEQ;
    end
    pc_d = pc_q;
    unique case (pcSel)
      PC_SEQ:    pc_d = pc_q + ADDR_W'(1);
      PC_BRANCH: pc_d = branchTgt;
      PC_JUMP:   pc_d = jumpTgt;
      default:   pc_d = pc_q;
    endcase
  end

  // Track the single outstanding memory access so its returning word can be
  // tagged with the PC it was fetched from
  always_comb begin
    inflight_d   = issue;
    inflightPc_d = issue ? pc_q : inflightPc_q;
  end

  // Decode-facing registers: a redirect squashes them, a stall freezes them,
  // otherwise they take the queue head or fall back to an invalid NOP
  always_comb begin
    inst_d      = inst_q;
    instPc_d    = instPc_q;
    instValid_d = instValid_q;
    if (redirect) begin
      inst_d      = NOP_W;
      instPc_d    = '0;
      instValid_d = 1'b0;
    end else if (!Stall_i) begin
      if (fifoCount != '0) begin
        inst_d      = fifoHead[DATA_W-1:0];
        instPc_d    = fifoHead[ENTRY_W-1:DATA_W];
        instValid_d = 1'b1;
      end else begin
        inst_d      = NOP_W;
        instPc_d    = '0;
        instValid_d = 1'b0;
      end
    end
  end

  // All fetch-side state, returned to its reset values the moment reset rises
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      inst_q       <= NOP_W;
      instPc_q     <= '0;
      instValid_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      inst_q       <= inst_d;
      instPc_q     <= instPc_d;
      instValid_q  <= instValid_d;
    end
  end

  assign fifoPushData = {inflightPc_q, ImemData_i};

  // The redirect clear also throws away the word arriving this cycle, since
  // clear overrides the push inside the queue
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetchFifo (
    .Clk_i      (Clk_i),
    .Reset_i    (Reset_i),
    .Clear_i    (redirect),
    .Push_i     (inflight_q),
    .PushData_i (fifoPushData),
    .Pop_i      (pop),
    .HeadData_o (fifoHead),
    .Count_o    (fifoCount)
  );

  assign ImemReq_o   = issue;
  assign ImemAddr_o  = pc_q;
  assign Inst_o      = inst_q;
  assign InstPc_o    = instPc_q;
  assign InstValid_o = instValid_q;

endmodule
